// File: rtl/max_layer_if.sv
// Handshake and data bundle between the logit source and max_layer.
// Carries run/valid control, the logit bus and the per-row result buses.
interface max_layer_if #(
    parameter int N        = 10,
    parameter int CHAR_NUM = 200,
    parameter int N_LEN    = 16,
    parameter int CHAR_LEN = 8
) ();
    logic                         run;
    logic [N*CHAR_NUM*N_LEN-1:0]  d;
    logic                         busy;
    logic                         valid;
    logic [N*N_LEN-1:0]           q_max;
    logic [N*CHAR_LEN-1:0]        q_idx;

    modport master (
        output run, d,
        input  busy, valid, q_max, q_idx
    );

    modport slave (
        input  run, d,
        output busy, valid, q_max, q_idx
    );
endinterface

// File: rtl/max_layer.sv
// Per-row signed maximum search, LANES elements per row per cycle.
// Optional argmax tracking is enabled by defining MAX_ARGMAX_EN.
module max_layer #(
    parameter int N        = 10,
    parameter int CHAR_NUM = 200,
    parameter int N_LEN    = 16,
    parameter int LANES    = 8,
    parameter int CHAR_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    max_layer_if.slave bus
);
    localparam int K  = CHAR_NUM / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int LV = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LP = 1 << LV;
    localparam logic signed [N_LEN-1:0] MINV = {1'b1, {(N_LEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic signed [N_LEN-1:0] r_max  [N];
    logic signed [N_LEN-1:0] w_tv   [N][LV+1][LP];
    logic signed [N_LEN-1:0] w_cmax [N];
    int                      w_base;
    logic                    w_start;
    logic                    w_last;
`ifdef MAX_ARGMAX_EN
    logic [CHAR_LEN-1:0]     r_idx  [N];
    logic [CHAR_LEN-1:0]     w_ti   [N][LV+1][LP];
    logic [CHAR_LEN-1:0]     w_cidx [N];
`endif

    assign w_base  = int'(r_cnt) * LANES;
    assign w_start = bus.run && (r_state != S_SCAN);
    assign w_last  = (r_state == S_SCAN) && (r_cnt == CW'(K - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; run is ignored while scanning
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.run) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  if (bus.run) w_state_nxt = S_SCAN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Chunk reduction tree: right operand wins only when strictly greater,
    // so the lower index is kept on ties; pad slots hold the most-negative value
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int l = 0; l <= LV; l++) begin
                for (int k = 0; k < LP; k++) begin
                    w_tv[r][l][k] = MINV;
`ifdef MAX_ARGMAX_EN
                    w_ti[r][l][k] = '0;
`endif
                end
            end
            for (int k = 0; k < LANES; k++) begin
                w_tv[r][0][k] =
                    bus.d[(r*CHAR_NUM + w_base + k)*N_LEN +: N_LEN];
`ifdef MAX_ARGMAX_EN
                w_ti[r][0][k] = CHAR_LEN'(w_base + k);
`endif
            end
            for (int l = 1; l <= LV; l++) begin
                for (int k = 0; k < (LP >> l); k++) begin
                    if (w_tv[r][l-1][2*k+1] > w_tv[r][l-1][2*k]) begin
                        w_tv[r][l][k] = w_tv[r][l-1][2*k+1];
`ifdef MAX_ARGMAX_EN
                        w_ti[r][l][k] = w_ti[r][l-1][2*k+1];
`endif
                    end else begin
                        w_tv[r][l][k] = w_tv[r][l-1][2*k];
`ifdef MAX_ARGMAX_EN
                        w_ti[r][l][k] = w_ti[r][l-1][2*k];
`endif
                    end
                end
            end
            w_cmax[r] = w_tv[r][LV][0];
`ifdef MAX_ARGMAX_EN
            w_cidx[r] = w_ti[r][LV][0];
`endif
        end
    end

    // Chunk counter and running maxima; chunk must beat the running max strictly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int r = 0; r < N; r++) begin
                r_max[r] <= '0;
`ifdef MAX_ARGMAX_EN
                r_idx[r] <= '0;
`endif
            end
        end else if (w_start) begin
            r_cnt <= '0;
            for (int r = 0; r < N; r++) begin
                r_max[r] <= MINV;
`ifdef MAX_ARGMAX_EN
                r_idx[r] <= '0;
`endif
            end
        end else if (r_state == S_SCAN) begin
            if (!w_last) r_cnt <= r_cnt + 1'b1;
            for (int r = 0; r < N; r++) begin
                if (w_cmax[r] > r_max[r]) begin
                    r_max[r] <= w_cmax[r];
`ifdef MAX_ARGMAX_EN
                    r_idx[r] <= w_cidx[r];
`endif
                end
            end
        end
    end

    assign bus.busy  = (r_state == S_SCAN);
    assign bus.valid = (r_state == S_DONE);

    // Pack the register banks onto the result buses
    always_comb begin
        bus.q_max = '0;
        bus.q_idx = '0;
        for (int r = 0; r < N; r++) begin
            bus.q_max[r*N_LEN +: N_LEN] = r_max[r];
`ifdef MAX_ARGMAX_EN
            bus.q_idx[r*CHAR_LEN +: CHAR_LEN] = r_idx[r];
`endif
        end
    end
endmodule

// File: tb/tb_max_layer.sv
// Directed self-checking bench for max_layer.
// Expected maxima and indices are written by hand per vector.
module tb_max_layer;
    localparam int N        = 10;
    localparam int CHAR_NUM = 200;
    localparam int N_LEN    = 16;
    localparam int LANES    = 8;
    localparam int CHAR_LEN = 8;
    localparam int K        = CHAR_NUM / LANES;
    localparam int W        = N * CHAR_NUM * N_LEN;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    logic [W-1:0]        dd;
    logic [N_LEN-1:0]    exp_max [N];
    logic [CHAR_LEN-1:0] exp_idx [N];

    max_layer_if #(
        .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN)
    ) ifc ();

    max_layer #(
        .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN),
        .LANES(LANES), .CHAR_LEN(CHAR_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [N_LEN-1:0] v);
        for (int r = 0; r < N; r++)
            for (int j = 0; j < CHAR_NUM; j++)
                dd[(r*CHAR_NUM + j)*N_LEN +: N_LEN] = v;
    endtask

    task automatic put(input int r, input int j, input logic [N_LEN-1:0] v);
        dd[(r*CHAR_NUM + j)*N_LEN +: N_LEN] = v;
    endtask

    task automatic set_exp(input logic [N_LEN-1:0] m);
        for (int r = 0; r < N; r++) begin
            exp_max[r] = m;
            exp_idx[r] = '0;
        end
    endtask

    task automatic chk_rows(input string tag);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s_max%0d", tag, r),
                64'(ifc.q_max[r*N_LEN +: N_LEN]), 64'(exp_max[r]));
`ifdef MAX_ARGMAX_EN
            chk($sformatf("%s_idx%0d", tag, r),
                64'(ifc.q_idx[r*CHAR_LEN +: CHAR_LEN]), 64'(exp_idx[r]));
`else
            chk($sformatf("%s_idx%0d", tag, r),
                64'(ifc.q_idx[r*CHAR_LEN +: CHAR_LEN]), 64'd0);
`endif
        end
    endtask

    // Pulse run, optionally re-pulse it at SCAN cycle 'extra',
    // and require valid exactly K edges after the accepted run.
    task automatic run_scan(input string tag, input int extra);
        ifc.d   = dd;
        ifc.run = 1'b1;
        step();
        ifc.run = 1'b0;
        chk({tag, "_busy"}, 64'(ifc.busy), 64'd1);
        chk({tag, "_vlow"}, 64'(ifc.valid), 64'd0);
        for (int i = 1; i < K; i++) begin
            ifc.run = (i == extra);
            step();
            ifc.run = 1'b0;
            if (ifc.valid !== 1'b0 || ifc.busy !== 1'b1)
                chk($sformatf("%s_lat%0d", tag, i),
                    64'({ifc.busy, ifc.valid}), 64'b10);
        end
        step();
        chk({tag, "_valid"}, 64'(ifc.valid), 64'd1);
        chk({tag, "_bdone"}, 64'(ifc.busy), 64'd0);
        chk_rows(tag);
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        rst     = 1'b1;
        ifc.run = 1'b0;
        dd      = '0;
        ifc.d   = dd;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 64'(ifc.valid), 64'd0);
            chk("idle_busy", 64'(ifc.busy), 64'd0);
            chk("idle_qmax", 64'(ifc.q_max == '0), 64'd1);
        end
        chk("idle_qidx", 64'(ifc.q_idx == '0), 64'd1);

        fill(16'hFF00);
        set_exp(16'h0100);
        for (int r = 0; r < N; r++) begin
            put(r, 17*r + 3, 16'h0100);
            exp_idx[r] = CHAR_LEN'(17*r + 3);
        end
        run_scan("onehot", -1);

        fill(16'h8000);
        set_exp(16'h8000);
        run_scan("allmin", -1);

        put(9, 199, 16'h7FFF);
        exp_max[9] = 16'h7FFF;
        exp_idx[9] = 8'd199;
        run_scan("maxpos", -1);

        fill(16'hFFF0);
        set_exp(16'hFFF0);
        put(0, 5, 16'h0040);
        put(0, 150, 16'h0040);
        exp_max[0] = 16'h0040;
        exp_idx[0] = 8'd5;
        run_scan("tie", -1);

        fill(16'hFF00);
        for (int r = 0; r < N; r++) begin
            put(r, 199 - 17*r, 16'h0200 + 16'(r));
            exp_max[r] = 16'h0200 + 16'(r);
            exp_idx[r] = CHAR_LEN'(199 - 17*r);
        end
        run_scan("rerun", 10);

        ifc.d   = dd;
        ifc.run = 1'b1;
        step();
        ifc.run = 1'b0;
        repeat (11) step();
        chk("rst_pre_busy", 64'(ifc.busy), 64'd1);
        rst = 1'b1;
        ifc.run = 1'b1;
        step();
        rst = 1'b0;
        ifc.run = 1'b0;
        chk("rst_valid", 64'(ifc.valid), 64'd0);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_qmax", 64'(ifc.q_max == '0), 64'd1);
        chk("rst_qidx", 64'(ifc.q_idx == '0), 64'd1);
        step();
        chk("rst_idle", 64'(ifc.busy), 64'd0);

        fill(16'hF000);
        set_exp(16'hF000);
        put(3, 77, 16'h1234);
        exp_max[3] = 16'h1234;
        exp_idx[3] = 8'd77;
        put(6, 0, 16'h0001);
        exp_max[6] = 16'h0001;
        run_scan("after_rst", -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/max_layer.md
# max_layer

Per-row maximum search stage that sits directly upstream of the softmax layer in the training datapath. It scans the `N` rows of `CHAR_NUM` signed fixed-point logits, `LANES` elements per row per cycle. It produces the packed per-row maximum bus that the softmax layer consumes as `d_max`. It is a multi-cycle, run/valid-controlled block that shares the softmax layer's `run`/`valid` convention.

## Interface
- `N`, 10, rows processed in parallel
- `CHAR_NUM`, 200, logits per row
- `N_LEN`, 16, logit width, signed two's complement
- `LANES`, 8, elements compared per row per cycle; `CHAR_NUM % LANES == 0` is required
- `CHAR_LEN`, 8, index width for the optional argmax output
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  start pulse; accepted in IDLE or DONE only
- `d`  in  `N*CHAR_NUM*N_LEN`  logits; row i at `[i*CHAR_NUM*N_LEN +: CHAR_NUM*N_LEN]`, element j of a row at `[j*N_LEN +: N_LEN]`; held stable from the accepted `run` until `valid`
- `busy`  out  1  high in SCAN
- `valid`  out  1  result ready; high in DONE
- `q_max`  out  `N*N_LEN`  per-row maximum, row i at `[i*N_LEN +: N_LEN]`; directly drives softmax `d_max`
- `q_idx`  out  `N*CHAR_LEN`  per-row argmax index (MAX_ARGMAX_EN only)

## Operation
- K = `CHAR_NUM/LANES` chunks; chunk counter `cnt` is `$clog2(K)` bits wide.
- FSM states:
  - IDLE: waits for `run`.
  - SCAN: one chunk per cycle.
  - DONE: `valid`=1; holds `q_max`.
- IDLE or DONE with `run`=1 → SCAN. In the same edge: `cnt`←0, every running max ← most-negative value (`1` followed by `N_LEN-1` zeros), `valid`←0.
- In SCAN, each row compares its running max against the `LANES` elements at indices `cnt*LANES .. cnt*LANES+LANES-1`.
  - The comparison is a combinational signed reduction tree.
  - The greater value is registered.
- SCAN with `cnt==K-1` → DONE, with the final update applied. Otherwise `cnt`←`cnt+1`.
- `run` asserted during SCAN is ignored. The scan is not restarted.
- Comparison is signed, strict greater-than, so the lowest index wins ties. Widths are not changed and no arithmetic saturation is applied.
- `q_max` is the register bank itself. It is only meaningful while `valid`=1.

## Timing
- Reset values: state IDLE; `busy`=0, `valid`=0, `q_max`=0, `q_idx`=0, `cnt`=0.
- `run` sampled high at edge e0 → `busy`=1 in cycles e0..e0+K-1.
- `valid`=1 from edge e0+K onward, until the next accepted `run` edge (valid is sticky).
- Latency from accepted `run` to `valid` is K cycles. At the defaults this is 25.
- A `run` sampled during DONE clears `valid` in the next cycle, and the new scan starts immediately. There is no idle cycle between scans.
- `rst` mid-SCAN or mid-DONE returns the block to IDLE at that edge. All outputs take their reset values, and any partial result is discarded.
- `rst` and `run` asserted together: `rst` wins.
- `d` is sampled combinationally every SCAN cycle. Changing it during SCAN corrupts the result; this is not flagged.

## Configuration
- `MAX_ARGMAX_EN` defined:
  - Each row keeps a `CHAR_LEN`-bit index register, updated together with its max. The index is the position of the winning element, lowest index on ties.
  - The index register initialises to 0 on an accepted `run`.
  - `q_idx` is valid alongside `q_max`. Its intended use is accuracy counting.
- Not defined:
  - `q_idx` is driven constant 0.
  - No index registers or index comparison logic are synthesised.

## Test plan
- Reset, then idle: `valid`=0, `busy`=0, `q_max`=0 for 10 cycles with `run`=0.
- Row i has element (17*i+3) = 0x0100 and all other elements 0xFF00 (negative); pulse `run`. Required: `valid` rises exactly 25 cycles later; `q_max` row i = 0x0100; `q_idx` row i = 17*i+3 when the macro is enabled.
- All elements = 0x8000 (most negative): `q_max` = 0x8000 for all rows, `q_idx` = 0. Max value 0x7FFF at index 199 of row 9 only: row 9 = 0x7FFF, `q_idx` = 199.
- Tie: 0x0040 at indices 5 and 150 of row 0, everything else smaller. Required: `q_max` = 0x0040, `q_idx` = 5.
- Re-`run` with new data at the first DONE cycle: `valid` low for exactly 25 cycles, then the new maxima. A second `run` pulse at SCAN cycle 10 changes nothing.
- `rst` at SCAN cycle 12: next cycle IDLE, all outputs 0. A following `run` yields correct results 25 cycles later.
